wb_write_arbiter: RTL and testbench

Write-back arbiter in front of the 32x32 register file's single write port (`we3`/`wa3`/`wd3`). Merges the in-order pipeline write-back, which has strict priority and no backpressure, with results from a long-latency unit (multiply/divide) held in a small FIFO. Drives the register file through registered outputs, so every write reaches the register file exactly one cycle after it is selected.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/wb_write_arbiter_if.sv | 33 +++
 rtl/wb_fifo.sv | 90 +++++++++
 rtl/wb_write_arbiter.sv | 112 +++++++++++
 tb/tb_wb_write_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types for the write-back path: register address/data widths and
// the write-request record carried through the long-latency result FIFO.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wa;
    logic [DATA_W-1:0]     wd;
  } wb_req_t;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Handshake bundle between the pipeline / long-latency unit and the register
// file write port. The arbiter uses the slave modport.
interface wb_write_arbiter_if;
  import cpu_pkg::*;

  logic                  pipe_we;
  logic [REG_ADDR_W-1:0] pipe_wa;
  logic [DATA_W-1:0]     pipe_wd;

  logic                  lu_valid;
  logic                  lu_ready;
  logic [REG_ADDR_W-1:0] lu_wa;
  logic [DATA_W-1:0]     lu_wd;

  logic                  we3;
  logic [REG_ADDR_W-1:0] wa3;
  logic [DATA_W-1:0]     wd3;

  modport master (
    output pipe_we, pipe_wa, pipe_wd,
    output lu_valid, lu_wa, lu_wd,
    input  lu_ready,
    input  we3, wa3, wd3
  );

  modport slave (
    input  pipe_we, pipe_wa, pipe_wd,
    input  lu_valid, lu_wa, lu_wd,
    output lu_ready,
    output we3, wa3, wd3
  );

endinterface

// File: rtl/wb_fifo.sv
// Small FIFO of pending long-latency write-backs. With WB_SCOREBOARD_EN it
// also tracks per-slot valid bits and exposes slot addresses for pend_busy.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  wb_req_t               i_data,
  input  logic                  i_pop,
  output wb_req_t               o_head,
  output logic [CW-1:0]         o_count,
  output logic                  o_full,
  output logic                  o_empty
`ifdef WB_SCOREBOARD_EN
  ,
  output logic [REG_ADDR_W-1:0] o_entry_wa [DEPTH],
  output logic [DEPTH-1:0]      o_valid
`endif
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  wb_req_t       r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Storage carries no reset; only pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);

`ifdef WB_SCOREBOARD_EN
  logic [DEPTH-1:0] r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      if (i_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
      end
      if (i_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_entry_wa[i] = r_mem[i].wa;
    end
  end

  assign o_valid = r_valid;
`endif

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline write-back wins, queued
// long-latency results drain on idle cycles. WB_SCOREBOARD_EN enables pend_busy.
module wb_write_arbiter
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  wb_write_arbiter_if.slave      bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [31:0]            pend_busy
);

  logic                  w_full;
  logic                  w_empty;
  logic                  w_lu_acc;
  logic                  w_push;
  logic                  w_pipe_sel;
  logic                  w_pop;
  wb_req_t               w_head;
  wb_req_t               w_push_req;

  logic                  r_we3;
  logic [REG_ADDR_W-1:0] r_wa3;
  logic [DATA_W-1:0]     r_wd3;

  // Writes to r0 are dropped at the door: they neither queue nor block a pop.
  assign w_lu_acc   = bus.lu_valid && !w_full;
  assign w_push     = w_lu_acc && (bus.lu_wa != '0);
  assign w_push_req = '{wa: bus.lu_wa, wd: bus.lu_wd};
  assign w_pipe_sel = bus.pipe_we && (bus.pipe_wa != '0);
  assign w_pop      = !w_pipe_sel && !w_empty;

  assign bus.lu_ready = !w_full;

`ifdef WB_SCOREBOARD_EN
  logic [REG_ADDR_W-1:0] w_entry_wa [DEPTH];
  logic [DEPTH-1:0]      w_valid;
`endif

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_data    (w_push_req),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_count   (fifo_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
`ifdef WB_SCOREBOARD_EN
    ,
    .o_entry_wa(w_entry_wa),
    .o_valid   (w_valid)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we3 <= 1'b0;
      r_wa3 <= '0;
      r_wd3 <= '0;
    end else if (w_pipe_sel) begin
      r_we3 <= 1'b1;
      r_wa3 <= bus.pipe_wa;
      r_wd3 <= bus.pipe_wd;
    end else if (w_pop) begin
      r_we3 <= 1'b1;
      r_wa3 <= w_head.wa;
      r_wd3 <= w_head.wd;
    end else begin
      r_we3 <= 1'b0;
    end
  end

  assign bus.we3 = r_we3;
  assign bus.wa3 = r_wa3;
  assign bus.wd3 = r_wd3;

`ifdef WB_SCOREBOARD_EN
  logic        r_out_from_fifo;
  logic [31:0] w_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_from_fifo <= 1'b0;
    end else begin
      r_out_from_fifo <= w_pop;
    end
  end

  // A register stays busy until its queued result has actually left the output stage.
  always_comb begin
    w_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i]) begin
        w_busy[w_entry_wa[i]] = 1'b1;
      end
    end
    if (r_out_from_fifo) begin
      w_busy[r_wa3] = 1'b1;
    end
    w_busy[0] = 1'b0;
  end

  assign pend_busy = w_busy;
`else
  assign pend_busy = 32'h0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: a queue-based model checked every cycle plus
// directed scenarios with literal expectations. Honours WB_SCOREBOARD_EN.
module tb_wb_write_arbiter;
  import cpu_pkg::*;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef WB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] fifoCount;
  logic [31:0]   pendBusy;
  int            testsRun = 0;
  int            testsFailed = 0;

  wb_write_arbiter_if bus();

  wb_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fifo_count(fifoCount),
    .pend_busy (pendBusy)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of pending results and the last selected write.
  wb_req_t     mq[$];
  logic        mWe = 1'b0;
  logic [4:0]  mWa = '0;
  logic [31:0] mWd = '0;
  logic        mOutFifo = 1'b0;
  bit          mAcc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mWe      <= 1'b0;
      mWa      <= '0;
      mWd      <= '0;
      mOutFifo <= 1'b0;
    end else begin
      mAcc = bus.lu_valid && (mq.size() != DEPTH);
      if (bus.pipe_we && bus.pipe_wa != 5'd0) begin
        mWe      <= 1'b1;
        mWa      <= bus.pipe_wa;
        mWd      <= bus.pipe_wd;
        mOutFifo <= 1'b0;
      end else if (mq.size() != 0) begin
        mWe      <= 1'b1;
        mWa      <= mq[0].wa;
        mWd      <= mq[0].wd;
        mOutFifo <= 1'b1;
        void'(mq.pop_front());
      end else begin
        mWe      <= 1'b0;
        mOutFifo <= 1'b0;
      end
      if (mAcc && bus.lu_wa != 5'd0) begin
        mq.push_back('{wa: bus.lu_wa, wd: bus.lu_wd});
      end
    end
  end

  function automatic logic [31:0] expPend();
    logic [31:0] r;
    r = '0;
`ifdef WB_SCOREBOARD_EN
    foreach (mq[i]) r[mq[i].wa] = 1'b1;
    if (mOutFifo) r[mWa] = 1'b1;
    r[0] = 1'b0;
`endif
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("cyc_we3", 32'(bus.we3), 32'(mWe));
      checkOutput("cyc_wa3", 32'(bus.wa3), 32'(mWa));
      checkOutput("cyc_wd3", bus.wd3, mWd);
      checkOutput("cyc_count", 32'(fifoCount), 32'(mq.size()));
      checkOutput("cyc_ready", 32'(bus.lu_ready), 32'(mq.size() != DEPTH));
      checkOutput("cyc_pend", pendBusy, expPend());
    end
  end

  task automatic applyStimulus(input logic pwe, input logic [4:0] pwa, input logic [31:0] pwd,
                               input logic lv, input logic [4:0] lwa, input logic [31:0] lwd);
    @(negedge clk);
    bus.pipe_we  = pwe;
    bus.pipe_wa  = pwa;
    bus.pipe_wd  = pwd;
    bus.lu_valid = lv;
    bus.lu_wa    = lwa;
    bus.lu_wd    = lwd;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    bus.pipe_we  = 1'b0;
    bus.pipe_wa  = '0;
    bus.pipe_wd  = '0;
    bus.lu_valid = 1'b0;
    bus.lu_wa    = '0;
    bus.lu_wd    = '0;

    idle();
    idle();
    checkOutput("rst_we3", 32'(bus.we3), 32'd0);
    checkOutput("rst_wa3", 32'(bus.wa3), 32'd0);
    checkOutput("rst_count", 32'(fifoCount), 32'd0);
    checkOutput("rst_ready", 32'(bus.lu_ready), 32'd1);
    rst = 1'b0;

    // Pipeline only
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    idle();
    checkOutput("pipe_we3", 32'(bus.we3), 32'd1);
    checkOutput("pipe_wa3", 32'(bus.wa3), 32'd5);
    checkOutput("pipe_wd3", bus.wd3, 32'hDEADBEEF);
    idle();
    checkOutput("pipe_we3_off", 32'(bus.we3), 32'd0);
    checkOutput("pipe_wa3_hold", 32'(bus.wa3), 32'd5);

    // Priority and drain
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h11);
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
    checkOutput("prio_cnt0", 32'(fifoCount), 32'd1);
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
    checkOutput("prio_wa3_a", 32'(bus.wa3), 32'd3);
    checkOutput("prio_cnt1", 32'(fifoCount), 32'd1);
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
    checkOutput("prio_wa3_b", 32'(bus.wa3), 32'd3);
    checkOutput("prio_cnt2", 32'(fifoCount), 32'd1);
    idle();
    checkOutput("prio_wa3_c", 32'(bus.wa3), 32'd3);
    checkOutput("prio_cnt3", 32'(fifoCount), 32'd1);
    idle();
    checkOutput("prio_drain_we3", 32'(bus.we3), 32'd1);
    checkOutput("prio_drain_wa3", 32'(bus.wa3), 32'd7);
    checkOutput("prio_drain_wd3", bus.wd3, 32'h11);
    checkOutput("prio_cnt4", 32'(fifoCount), 32'd0);

    // Full FIFO
    applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hA0);
    applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd11, 32'hB0);
    checkOutput("full_cnt1", 32'(fifoCount), 32'd1);
    checkOutput("full_ready1", 32'(bus.lu_ready), 32'd1);
    applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd12, 32'hC0);
    checkOutput("full_cnt2", 32'(fifoCount), 32'd2);
    checkOutput("full_ready0", 32'(bus.lu_ready), 32'd0);
    idle();
    checkOutput("full_still", 32'(fifoCount), 32'd2);
    idle();
    checkOutput("full_pop_wa3", 32'(bus.wa3), 32'd10);
    checkOutput("full_pop_wd3", bus.wd3, 32'hA0);
    checkOutput("full_ready_back", 32'(bus.lu_ready), 32'd1);
    idle();
    checkOutput("full_pop2_wa3", 32'(bus.wa3), 32'd11);
    checkOutput("full_cnt_empty", 32'(fifoCount), 32'd0);

    // Register 0 handling
    applyStimulus(1'b1, 5'd2, 32'h2, 1'b1, 5'd20, 32'h200);
    applyStimulus(1'b1, 5'd0, 32'hBAD, 1'b1, 5'd0, 32'h999);
    checkOutput("r0_cnt1", 32'(fifoCount), 32'd1);
    idle();
    checkOutput("r0_drain_wa3", 32'(bus.wa3), 32'd20);
    checkOutput("r0_drain_wd3", bus.wd3, 32'h200);
    checkOutput("r0_cnt0", 32'(fifoCount), 32'd0);
    applyStimulus(1'b1, 5'd0, 32'hBAD, 1'b1, 5'd0, 32'h999);
    idle();
    checkOutput("r0_no_we3", 32'(bus.we3), 32'd0);
    checkOutput("r0_cnt_stay", 32'(fifoCount), 32'd0);

    // Scoreboard
    applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h99);
    applyStimulus(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'h0);
    checkOutput("sb_busy_a", 32'(pendBusy[9]), 32'(SB));
    applyStimulus(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'h0);
    checkOutput("sb_busy_b", 32'(pendBusy[9]), 32'(SB));
    idle();
    checkOutput("sb_busy_c", 32'(pendBusy[9]), 32'(SB));
    idle();
    checkOutput("sb_write_wa3", 32'(bus.wa3), 32'd9);
    checkOutput("sb_busy_d", 32'(pendBusy[9]), 32'(SB));
    idle();
    checkOutput("sb_clear", 32'(pendBusy[9]), 32'd0);

    // Reset during traffic
    applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd12, 32'hC);
    applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd13, 32'hD);
    applyStimulus(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'h0);
    checkOutput("mid_cnt2", 32'(fifoCount), 32'd2);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_we3", 32'(bus.we3), 32'd0);
    checkOutput("mid_wa3", 32'(bus.wa3), 32'd0);
    checkOutput("mid_wd3", bus.wd3, 32'd0);
    checkOutput("mid_cnt", 32'(fifoCount), 32'd0);
    checkOutput("mid_ready", 32'(bus.lu_ready), 32'd1);
    checkOutput("mid_pend", pendBusy, 32'd0);
    idle();
    rst = 1'b0;
    idle();
    idle();
    checkOutput("post_we3", 32'(bus.we3), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
